// File: rtl/seg7_pkg.sv
// Shared types and glyph data for the counter display scanner.
// Glyphs are stored active-high as {g,f,e,d,c,b,a}; the top module applies panel polarity.
package seg7_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [3:0] AN_OFF  = 4'h0;

  // Entry 15 is leftmost, entry 0 rightmost.
  localparam logic [15:0][6:0] HEX_GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hex2seg(input logic [3:0] value);
    return HEX_GLYPHS[value];
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-high 7-segment glyph.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex2seg(hex_i);

endmodule

// File: rtl/count_seg7_scanner.sv
// Captures distinct counter values into a 4-deep history and scans them onto a
// 4-digit 7-segment display, newest on digit 0, with a sticky 15->0 wrap flag on its dp.
module count_seg7_scanner
  import seg7_pkg::*;
#(
  parameter int unsigned SHOW_CYCLES  = 50000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] count_in,
  input  logic       hold,
  input  logic       wrap_clr,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       wrap_seen
);

  localparam int unsigned MAX_CYCLES = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int          TW         = $clog2(MAX_CYCLES + 1);
  localparam logic [TW-1:0] SHOW_LOAD  = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0] BLANK_LOAD = TW'(BLANK_CYCLES - 1);

  localparam logic [3:0] AN_POL  = {4{ACTIVE_LOW}};
  localparam logic [6:0] SEG_POL = {7{ACTIVE_LOW}};
  localparam logic       DP_POL  = ACTIVE_LOW;

  logic [3:0]    sync1_q, sync2_q, last_q;
  logic [3:0]    hist_q [4];
  logic          wrap_q;
  scan_state_e   state_q;
  logic [1:0]    idx_q;
  logic [TW-1:0] timer_q;
  logic [3:0]    an_q;
  logic [6:0]    seg_q;
  logic          dp_q;

  logic [6:0]    glyph_w [4];
  logic          push_d;
  logic          wrap_push_d;

  // One decoder per history slot; the scan index then picks a glyph.
  for (genvar gi = 0; gi < 4; gi++) begin : g_dec
    seg7_hex_decoder u_dec (
      .hex_i (hist_q[gi]),
      .seg_o (glyph_w[gi])
    );
  end

  assign push_d      = !hold && (sync2_q != last_q);
  assign wrap_push_d = push_d && (last_q == 4'hF) && (sync2_q == 4'h0);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 4'h0;
      sync2_q <= 4'h0;
      last_q  <= 4'h0;
      for (int i = 0; i < 4; i++) hist_q[i] <= 4'h0;
      wrap_q  <= 1'b0;
      state_q <= BLANK;
      idx_q   <= 2'd0;
      timer_q <= '0;
      an_q    <= AN_OFF ^ AN_POL;
      seg_q   <= SEG_OFF ^ SEG_POL;
      dp_q    <= 1'b0 ^ DP_POL;
    end else begin
      sync1_q <= count_in;
      sync2_q <= sync1_q;

      // last only tracks pushed values, so a held change is pushed once on release.
      if (push_d) begin
        for (int i = 3; i > 0; i--) hist_q[i] <= hist_q[i-1];
        hist_q[0] <= sync2_q;
        last_q    <= sync2_q;
      end

      if (wrap_push_d)   wrap_q <= 1'b1;
      else if (wrap_clr) wrap_q <= 1'b0;

      case (state_q)
        BLANK: begin
          if (timer_q == '0) begin
            state_q <= SHOW;
            timer_q <= SHOW_LOAD;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        SHOW: begin
          if (timer_q == '0) begin
            state_q <= BLANK;
            idx_q   <= idx_q + 2'd1;
            timer_q <= BLANK_LOAD;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        default: begin
          state_q <= BLANK;
          timer_q <= '0;
        end
      endcase

      // Glyph follows the live history entry, so a push shows up one cycle later.
      if (state_q == SHOW) begin
        an_q  <= (4'b0001 << idx_q) ^ AN_POL;
        seg_q <= glyph_w[idx_q] ^ SEG_POL;
        dp_q  <= ((idx_q == 2'd0) && wrap_q) ^ DP_POL;
      end else begin
        an_q  <= AN_OFF ^ AN_POL;
        seg_q <= SEG_OFF ^ SEG_POL;
        dp_q  <= 1'b0 ^ DP_POL;
      end
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign wrap_seen = wrap_q;

endmodule

// File: tb/tb_count_seg7_scanner.sv
// Directed bench for count_seg7_scanner with a cycle-level behavioural model of the display.
module tb_count_seg7_scanner;

  localparam int S     = 4;
  localparam int B     = 2;
  localparam int FRAME = 4 * (S + B);

  logic       clk;
  logic       rst;
  logic [3:0] count_in;
  logic       hold;
  logic       wrap_clr;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       wrap_seen;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Active-high glyphs {g,f,e,d,c,b,a} for 0..F.
  logic [6:0] gly [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model state
  int         n_edges;
  int         q, dig;
  logic [3:0] m_hist [4];
  logic [3:0] m_last, d1, d2;
  logic       m_wrap, wrap_now;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp, exp_wrap;

  count_seg7_scanner #(
    .SHOW_CYCLES  (S),
    .BLANK_CYCLES (B),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .count_in  (count_in),
    .hold      (hold),
    .wrap_clr  (wrap_clr),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .wrap_seen (wrap_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL cyc %0d %s: got %h want %h", cyc, name, act, req);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_an(input logic [3:0] tgt);
    int k;
    for (k = 0; k < 4 * FRAME; k++) begin
      if (an === tgt) break;
      @(negedge clk);
    end
    if (k == 4 * FRAME) begin
      checks++;
      errors++;
      $display("FAIL cyc %0d wait_an: got %h want %h (timeout)", cyc, an, tgt);
    end
  endtask

  // Model: scan position from edges since reset release; history as a shift of
  // distinct values seen through a 2-sample delay of count_in.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        n_edges = 0;
        for (int i = 0; i < 4; i++) m_hist[i] = 4'h0;
        m_last = 4'h0; d1 = 4'h0; d2 = 4'h0; m_wrap = 1'b0;
        exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_wrap = 1'b0;
      end else begin
        n_edges++;
        exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
        if (n_edges >= B) begin
          q   = (n_edges - B) % FRAME;
          dig = q / (S + B);
          if ((q % (S + B)) < S) begin
            exp_an  = ~(4'(1 << dig));
            exp_seg = ~gly[m_hist[dig]];
            exp_dp  = !((dig == 0) && m_wrap);
          end
        end
        wrap_now = 1'b0;
        if (!hold && (d2 != m_last)) begin
          wrap_now = (m_last == 4'hF) && (d2 == 4'h0);
          for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
          m_hist[0] = d2;
          m_last    = d2;
        end
        if (wrap_now)      m_wrap = 1'b1;
        else if (wrap_clr) m_wrap = 1'b0;
        d2 = d1;
        d1 = count_in;
        exp_wrap = m_wrap;
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    @(negedge clk);
    forever begin
      check("an", 32'(an), 32'(exp_an));
      check("seg", 32'(seg), 32'(exp_seg));
      check("dp", 32'(dp), 32'(exp_dp));
      check("wrap_seen", 32'(wrap_seen), 32'(exp_wrap));
      @(negedge clk);
    end
  end

  task automatic startup_checks();
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'h1);
    check("rst_wrap", 32'(wrap_seen), 32'h0);
    rst = 1'b0;
    tick();
    check("first_blank_an", 32'(an), 32'hF);
    tick();
    check("first_show_an", 32'(an), 32'hE);
    check("first_show_seg", 32'(seg), 32'h40);
  endtask

  initial begin
    rst = 1'b1; count_in = 4'h0; hold = 1'b0; wrap_clr = 1'b0;
    // 1. reset and first digit timing
    tick(3);
    startup_checks();

    // 2. single distinct value, held stable
    count_in = 4'h5;
    tick(10);
    wait_an(4'hE);
    check("d0_is_5", 32'(seg), 32'h12);
    wait_an(4'hD);
    check("d1_is_0", 32'(seg), 32'h40);
    tick(FRAME);

    // 3. count through the wrap
    for (int v = 1; v <= 16; v++) begin
      count_in = 4'(v);
      tick(8);
    end
    check("wrap_set", 32'(wrap_seen), 32'h1);
    wait_an(4'hE);
    check("w_d0_seg", 32'(seg), 32'h40);
    check("w_d0_dp", 32'(dp), 32'h0);
    wait_an(4'hD);
    check("w_d1_seg", 32'(seg), 32'h0E);
    check("w_d1_dp", 32'(dp), 32'h1);
    wait_an(4'hB);
    check("w_d2_seg", 32'(seg), 32'h06);
    wait_an(4'h7);
    check("w_d3_seg", 32'(seg), 32'h21);

    // 4. clear, non-wrap jump, then clear colliding with a wrap push
    wrap_clr = 1'b1;
    tick();
    wrap_clr = 1'b0;
    check("wrap_clr", 32'(wrap_seen), 32'h0);
    count_in = 4'hE; tick(8);
    count_in = 4'h3; tick(8);
    check("no_wrap_14_3", 32'(wrap_seen), 32'h0);
    count_in = 4'hF; tick(8);
    count_in = 4'h0; tick(2);
    wrap_clr = 1'b1;
    tick();
    wrap_clr = 1'b0;
    check("set_beats_clr", 32'(wrap_seen), 32'h1);
    tick(4);

    // 5. hold freezes history, release pushes once
    count_in = 4'h7; tick(8);
    hold = 1'b1;
    count_in = 4'h9; tick(4);
    count_in = 4'h2; tick(8);
    hold = 1'b0;
    tick(8);
    wait_an(4'hE);
    check("hold_d0_2", 32'(seg), 32'h24);
    wait_an(4'hD);
    check("hold_d1_7", 32'(seg), 32'h78);
    wait_an(4'hB);
    check("hold_d2_0", 32'(seg), 32'h40);

    // 6. reset in the middle of digit 2
    wait_an(4'hB);
    tick();
    rst = 1'b1;
    tick();
    check("midrst_an", 32'(an), 32'hF);
    check("midrst_seg", 32'(seg), 32'h7F);
    check("midrst_dp", 32'(dp), 32'h1);
    check("midrst_wrap", 32'(wrap_seen), 32'h0);
    startup_checks();
    tick(FRAME + 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
